system_0_cpu_0_oci_trace_packer: RTL and testbench
==================================================

# system_0_cpu_0_oci_trace_packer

Parametrised trace-packing buffer for the CPU on-chip instrumentation (OCI) path. It accepts a stream of fixed-width trace entries and shift-packs them into a frame word with an entry count. Completed or flushed frames go into a small output FIFO with a valid/ready handshake. It also runs the end-of-test flush/drain sequence, raises `test_has_ended` once all captured trace has been read out, and reports FIFO overflow.

## Interface
- `ENTRY_W`, 2, bits per trace entry.
- `MAX_ENTRIES`, 15, entries per full frame; must be ≥ 2.
- `CNT_W`, 4, count width; requires `MAX_ENTRIES` < 2^`CNT_W`.
- `FIFO_AW`, 2, FIFO address width; depth = 2^`FIFO_AW`.
- `BUF_W` (derived), `ENTRY_W*MAX_ENTRIES` = 30, frame data width.

- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `entry_valid`  in  1  trace entry present this cycle; cannot be back-pressured.
- `entry_data`  in  `ENTRY_W`  trace entry.
- `test_ending`  in  1  level input; rising edge starts flush.
- `frame_ready`  in  1  consumer accepts the head frame.
- `dct_buffer`  out  `BUF_W`  live partial-frame register.
- `dct_count`  out  `CNT_W`  live entries in `dct_buffer`.
- `frame_valid`  out  1  FIFO non-empty.
- `frame_data`  out  `BUF_W`  head frame data.
- `frame_count`  out  `CNT_W`  head frame entry count, 1..`MAX_ENTRIES`.
- `fifo_level`  out  `FIFO_AW+1`  frames held, 0..depth.
- `overflow`  out  1  sticky; set when a frame is dropped.
- `drop_count`  out  8  dropped frames; saturates at 255.
- `test_has_ended`  out  1  flush complete and FIFO drained.

## Operation
- Packing: an accepted entry gives `dct_buffer <= {dct_buffer[BUF_W-ENTRY_W-1:0], entry_data}` and increments `dct_count`. The oldest entry ends up in the most significant occupied slot; unused upper bits are 0.
- Frame complete: an entry accepted while `dct_count == MAX_ENTRIES-1` pushes {`MAX_ENTRIES`, packed value including that entry} into the FIFO the same cycle. `dct_buffer` and `dct_count` clear to 0.
- FIFO push/pop:
  - Pop occurs on `frame_valid && frame_ready`.
  - Push while full with a simultaneous pop succeeds.
  - Push while full without a pop drops the new frame, sets `overflow`, and increments `drop_count`. FIFO contents are unchanged.
- States:
  - RUN (reset state): packs entries. Rising edge of `test_ending` (registered edge detect) → FLUSH.
  - FLUSH (one cycle): an entry valid this cycle is packed first. If the resulting count > 0, the partial frame is pushed with its count, subject to the overflow rule, and the buffer clears. Then → DRAIN.
  - DRAIN: `entry_valid` is ignored; pops continue. When `fifo_level == 0` → DONE.
  - DONE: `test_has_ended = 1`. Entries and `test_ending` are ignored. Only `reset` leaves DONE.
- Entry on the same cycle as the `test_ending` rising edge (still RUN): the entry is packed in RUN, and the flush in the next cycle includes it.
- Flush with count 0: no frame is pushed.
- Reset at any point, including mid-frame or mid-drain:
  - All outputs return to 0, FIFO empties, state = RUN.
  - `overflow` and `drop_count` clear.

## Timing
- All outputs are registered. Reset values: every output = 0.
- Entry at edge N is visible in `dct_buffer`/`dct_count` after edge N.
- A frame pushed at edge N gives `frame_valid = 1` after edge N, so the consumer can pop from edge N+1.
- Pop at edge N shows the next head, or `frame_valid = 0`, after edge N.
- `fifo_level` reflects push and pop of the same edge (net 0 when both occur).
- Flush latency: `test_ending` rises before edge N → edge detected at N → FLUSH cycle pushes at edge N+1.
- `test_has_ended` rises one edge after DRAIN observes `fifo_level == 0`.
- Sustained throughput: one entry per clock; one frame per clock popped.

## Test plan
- Defaults, `frame_ready = 1`, 15 entries 0,1,2,3,0,… → one frame: `frame_count = 15`, `frame_data = 30'h06C6C6C6`, `dct_count` returns to 0 after the last entry, no overflow.
- 5 entries 3,3,3,3,3 then `test_ending` rising → partial frame: `frame_count = 5`, `frame_data = 30'h3FF`. `test_has_ended = 1` two edges after the pop completes the drain.
- `frame_ready = 0`, 75 entries (5 full frames) → `fifo_level = 4`, `overflow = 1`, `drop_count = 1`. The popped frames match frames 1–4.
- FIFO full with `frame_ready = 1` on the same edge as the 15th entry of the next frame → no drop, `fifo_level` stays 4, `overflow = 0`.
- Entry value 2 on the same cycle `test_ending` rises, buffer previously empty → flushed frame: `frame_count = 1`, `frame_data = 2`.
- 7 entries, then `reset` for one cycle, then 15 entries → all outputs 0 after reset; the next frame has count 15 and contains no pre-reset data.

Source files
------------

// File: rtl/system_0_cpu_0_oci_trace_packer_if.sv
// Trace-entry input and packed-frame output bundle of the OCI trace packer.
// The packer owns the slave side; the producer/consumer owns the master side.
interface system_0_cpu_0_oci_trace_packer_if #(
    parameter int ENTRY_W     = 2,
    parameter int MAX_ENTRIES = 15,
    parameter int CNT_W       = 4,
    localparam int BUF_W      = ENTRY_W * MAX_ENTRIES
);
    logic               entry_valid;
    logic [ENTRY_W-1:0] entry_data;
    logic               test_ending;
    logic               frame_ready;
    logic               frame_valid;
    logic [BUF_W-1:0]   frame_data;
    logic [CNT_W-1:0]   frame_count;

    modport slave (
        input  entry_valid, entry_data, test_ending, frame_ready,
        output frame_valid, frame_data, frame_count
    );

    modport master (
        output entry_valid, entry_data, test_ending, frame_ready,
        input  frame_valid, frame_data, frame_count
    );
endinterface

// File: rtl/system_0_cpu_0_oci_trace_packer.sv
// Shift-packs trace entries into frames, queues frames in a small FIFO and
// runs the end-of-test flush/drain sequence.
module system_0_cpu_0_oci_trace_packer #(
    parameter int ENTRY_W     = 2,
    parameter int MAX_ENTRIES = 15,
    parameter int CNT_W       = 4,
    parameter int FIFO_AW     = 2,
    localparam int BUF_W      = ENTRY_W * MAX_ENTRIES
) (
    input  logic                clk,
    input  logic                reset,
    system_0_cpu_0_oci_trace_packer_if.slave bus,
    output logic [BUF_W-1:0]    dct_buffer,
    output logic [CNT_W-1:0]    dct_count,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                overflow,
    output logic [7:0]          drop_count,
    output logic                test_has_ended
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(MAX_ENTRIES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_ENTRIES - 1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic               tend_q;
    logic [BUF_W-1:0]   buf_q, buf_d, pk_buf;
    logic [CNT_W-1:0]   cnt_q, cnt_d, pk_cnt;
    logic [BUF_W-1:0]   mem_data_q [DEPTH];
    logic [CNT_W-1:0]   mem_cnt_q  [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               valid_q;
    logic               ovf_q;
    logic [7:0]         drop_q;
    logic               ended_q;
    logic               accept, push, pop, full, push_ok, drop;

    always_comb begin
        accept  = bus.entry_valid && (state_q == ST_RUN || state_q == ST_FLUSH);
        pk_buf  = accept ? {buf_q[BUF_W-ENTRY_W-1:0], bus.entry_data} : buf_q;
        pk_cnt  = accept ? cnt_q + CNT_W'(1) : cnt_q;
        push    = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                push = accept && (cnt_q == CNT_LAST);
                if (bus.test_ending && !tend_q)
                    state_d = ST_FLUSH;
            end
            // The flush cycle emits whatever is buffered, including an entry
            // arriving in this very cycle.
            ST_FLUSH: begin
                push    = (pk_cnt != '0);
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (level_q == '0)
                    state_d = ST_DONE;
            end
            default: state_d = state_q;
        endcase
        buf_d = push ? '0 : pk_buf;
        cnt_d = push ? '0 : pk_cnt;

        pop     = (level_q != '0) && bus.frame_ready;
        full    = (level_q == LVL_FULL);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + (FIFO_AW+1)'(1);
        else if (!push_ok && pop)
            level_d = level_q - (FIFO_AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            tend_q   <= 1'b0;
            buf_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            ended_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            tend_q  <= bus.test_ending;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            valid_q <= (level_d != '0);
            ended_q <= (state_q == ST_DONE);
            // When full with a simultaneous pop, wr_ptr equals rd_ptr: the
            // head slot is vacated and rewritten on the same edge.
            if (push_ok) begin
                mem_data_q[wr_ptr_q] <= pk_buf;
                mem_cnt_q[wr_ptr_q]  <= (state_q == ST_RUN) ? CNT_FULL : pk_cnt;
                wr_ptr_q             <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF)
                    drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign dct_buffer      = buf_q;
    assign dct_count       = cnt_q;
    assign fifo_level      = level_q;
    assign overflow        = ovf_q;
    assign drop_count      = drop_q;
    assign test_has_ended  = ended_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_data  = mem_data_q[rd_ptr_q];
    assign bus.frame_count = mem_cnt_q[rd_ptr_q];
endmodule

// File: tb/tb_system_0_cpu_0_oci_trace_packer.sv
// Directed-vector bench for the OCI trace packer: framing, flush/drain,
// overflow, full-with-pop and reset behaviour.
module tb_system_0_cpu_0_oci_trace_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        test_has_ended;
    int vectors = 0;
    int miscompares = 0;

    system_0_cpu_0_oci_trace_packer_if #(.ENTRY_W(2), .MAX_ENTRIES(15), .CNT_W(4)) bus ();

    system_0_cpu_0_oci_trace_packer #(
        .ENTRY_W(2), .MAX_ENTRIES(15), .CNT_W(4), .FIFO_AW(2)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .fifo_level(fifo_level),
        .overflow(overflow), .drop_count(drop_count), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] d);
        bus.entry_valid = 1'b1;
        bus.entry_data  = d;
        tick();
        bus.entry_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) send(d);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.entry_valid = 1'b0;
        bus.entry_data  = '0;
        bus.test_ending = 1'b0;
        bus.frame_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [50:0] all_out;
        do_reset();
        all_out = {dct_buffer, dct_count, bus.frame_valid, fifo_level, overflow, drop_count, test_has_ended};
        vectors++;
        if (all_out !== '0) begin
            $display("FAIL reset_outputs got %h want 0", all_out); miscompares++;
        end
    endtask

    task automatic test_full_frame();
        bus.frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        vectors++;
        if (bus.frame_valid !== 1'b1) begin
            $display("FAIL full_valid got %b want 1", bus.frame_valid); miscompares++;
        end
        vectors++;
        if (bus.frame_count !== 4'd15) begin
            $display("FAIL full_count got %0d want 15", bus.frame_count); miscompares++;
        end
        vectors++;
        if (bus.frame_data !== 30'h06C6C6C6) begin
            $display("FAIL full_data got %h want 06c6c6c6", bus.frame_data); miscompares++;
        end
        vectors++;
        if (dct_count !== 4'd0 || fifo_level !== 3'd1) begin
            $display("FAIL full_cnt_level got %0d/%0d want 0/1", dct_count, fifo_level); miscompares++;
        end
        tick();
        vectors++;
        if (bus.frame_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
            $display("FAIL full_pop got v%b l%0d o%b want v0 l0 o0", bus.frame_valid, fifo_level, overflow); miscompares++;
        end
    endtask

    task automatic test_flush_partial();
        bus.frame_ready = 1'b0;
        send_frame(2'd3, 5);
        vectors++;
        if (dct_count !== 4'd5 || dct_buffer !== 30'h3FF) begin
            $display("FAIL partial_buf got %0d/%h want 5/3ff", dct_count, dct_buffer); miscompares++;
        end
        bus.test_ending = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd5 || bus.frame_data !== 30'h3FF) begin
            $display("FAIL partial_frame got v%b c%0d d%h want v1 c5 d3ff", bus.frame_valid, bus.frame_count, bus.frame_data); miscompares++;
        end
        vectors++;
        if (dct_count !== 4'd0 || test_has_ended !== 1'b0) begin
            $display("FAIL partial_clear got c%0d e%b want c0 e0", dct_count, test_has_ended); miscompares++;
        end
        bus.frame_ready = 1'b1;
        tick();
        vectors++;
        if (bus.frame_valid !== 1'b0 || fifo_level !== 3'd0) begin
            $display("FAIL drain_pop got v%b l%0d want v0 l0", bus.frame_valid, fifo_level); miscompares++;
        end
        tick();
        vectors++;
        if (test_has_ended !== 1'b0) begin
            $display("FAIL ended_early got %b want 0", test_has_ended); miscompares++;
        end
        tick();
        vectors++;
        if (test_has_ended !== 1'b1) begin
            $display("FAIL ended got %b want 1", test_has_ended); miscompares++;
        end
        send(2'd1);
        vectors++;
        if (dct_count !== 4'd0 || test_has_ended !== 1'b1) begin
            $display("FAIL done_ignores got c%0d e%b want c0 e1", dct_count, test_has_ended); miscompares++;
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        bus.test_ending = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.frame_valid !== 1'b0 || fifo_level !== 3'd0) begin
            $display("FAIL empty_flush got v%b l%0d want v0 l0", bus.frame_valid, fifo_level); miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (test_has_ended !== 1'b1) begin
            $display("FAIL empty_ended got %b want 1", test_has_ended); miscompares++;
        end
    endtask

    task automatic test_overflow();
        logic [1:0]  vals [5]  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        logic [29:0] want [4]  = '{30'h15555555, 30'h2AAAAAAA, 30'h3FFFFFFF, 30'h00000000};
        do_reset();
        for (int f = 0; f < 5; f++) send_frame(vals[f], 15);
        vectors++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd1) begin
            $display("FAIL overflow got l%0d o%b d%0d want l4 o1 d1", fifo_level, overflow, drop_count); miscompares++;
        end
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.frame_valid !== 1'b1 || bus.frame_data !== want[k] || bus.frame_count !== 4'd15) begin
                $display("FAIL ovf_frame%0d got v%b d%h c%0d want v1 d%h c15", k, bus.frame_valid, bus.frame_data, bus.frame_count, want[k]); miscompares++;
            end
            tick();
        end
        vectors++;
        if (bus.frame_valid !== 1'b0) begin
            $display("FAIL ovf_empty got %b want 0", bus.frame_valid); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  vals [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [29:0] want [4] = '{30'h2AAAAAAA, 30'h3FFFFFFF, 30'h00000000, 30'h15555555};
        do_reset();
        for (int f = 0; f < 4; f++) send_frame(vals[f], 15);
        send_frame(2'd1, 14);
        bus.frame_ready = 1'b1;
        send(2'd1);
        bus.frame_ready = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0 || drop_count !== 8'd0) begin
            $display("FAIL fullpop got l%0d o%b d%0d want l4 o0 d0", fifo_level, overflow, drop_count); miscompares++;
        end
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.frame_valid !== 1'b1 || bus.frame_data !== want[k]) begin
                $display("FAIL b2b_frame%0d got v%b d%h want v1 d%h", k, bus.frame_valid, bus.frame_data, want[k]); miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_edge_entry();
        do_reset();
        bus.entry_valid = 1'b1;
        bus.entry_data  = 2'd2;
        bus.test_ending = 1'b1;
        tick();
        bus.entry_valid = 1'b0;
        vectors++;
        if (dct_count !== 4'd1 || bus.frame_valid !== 1'b0) begin
            $display("FAIL edge_pack got c%0d v%b want c1 v0", dct_count, bus.frame_valid); miscompares++;
        end
        tick();
        vectors++;
        if (bus.frame_valid !== 1'b1 || bus.frame_count !== 4'd1 || bus.frame_data !== 30'd2) begin
            $display("FAIL edge_frame got v%b c%0d d%h want v1 c1 d2", bus.frame_valid, bus.frame_count, bus.frame_data); miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [50:0] all_out;
        do_reset();
        send_frame(2'd1, 7);
        vectors++;
        if (dct_count !== 4'd7) begin
            $display("FAIL mid_count got %0d want 7", dct_count); miscompares++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        all_out = {dct_buffer, dct_count, bus.frame_valid, fifo_level, overflow, drop_count, test_has_ended};
        vectors++;
        if (all_out !== '0) begin
            $display("FAIL mid_reset got %h want 0", all_out); miscompares++;
        end
        send_frame(2'd3, 15);
        vectors++;
        if (bus.frame_count !== 4'd15 || bus.frame_data !== 30'h3FFFFFFF || fifo_level !== 3'd1) begin
            $display("FAIL post_reset got c%0d d%h l%0d want c15 d3fffffff l1", bus.frame_count, bus.frame_data, fifo_level); miscompares++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.entry_valid = 1'b0;
        bus.entry_data  = '0;
        bus.test_ending = 1'b0;
        bus.frame_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_flush_partial();
        test_flush_empty();
        test_overflow();
        test_back_to_back();
        test_edge_entry();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
